// File: rtl/bus_register_pkg.sv
// Shared types and helpers for the bus register family.
package bus_register_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } reg_op_t;

    // Select width for a lane count; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned lane_count);
        return (lane_count <= 1) ? 1 : $clog2(lane_count);
    endfunction

endpackage

// File: rtl/oneHotEncoder.sv
// Request-vector to index encoder; the highest-indexed set bit wins.
module oneHotEncoder #(
    parameter int unsigned INPUT_COUNT = 1,
    parameter int unsigned SEL_W       = 1
) (
    input  logic [INPUT_COUNT-1:0] req_i,
    output logic [SEL_W-1:0]       idx_o,
    output logic                   valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            if (req_i[i]) begin
                idx_o   = SEL_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_counter_register.sv
// Loadable up/down counter register with gated bus outputs and carry/zero flags.
// Optional load-collision detection is enabled by BUS_COUNTER_REGISTER_COLLISION_EN.
module bus_counter_register
    import bus_register_pkg::*;
#(
    parameter int unsigned       WIDTH         = 8,
    parameter int unsigned       INPUT_COUNT   = 1,
    parameter int unsigned       OUTPUT_COUNT  = 1,
    parameter logic [WIDTH-1:0]  DEFAULT_VALUE = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH*INPUT_COUNT-1:0]    busInputs,
    input  logic [INPUT_COUNT-1:0]          busReadEnable,
    input  logic [OUTPUT_COUNT-1:0]         busWriteEnable,
    input  logic                            incEnable,
    input  logic                            decEnable,
    output logic [WIDTH*OUTPUT_COUNT-1:0]   busOutputs,
    output logic [WIDTH-1:0]                currentValue,
    output logic                            carryOut,
    output logic                            zeroFlag
`ifdef BUS_COUNTER_REGISTER_COLLISION_EN
    ,
    output logic                            collisionError,
    input  logic                            clearError
`endif
);

    localparam int unsigned SEL_W = sel_width(INPUT_COUNT);

    logic [WIDTH-1:0] state_q, state_d;
    logic             carry_q, carry_d;
    logic [SEL_W-1:0] lane_sel;
    logic             load_req;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH:0]   inc_sum, dec_diff;
    reg_op_t          op;

    oneHotEncoder #(
        .INPUT_COUNT(INPUT_COUNT),
        .SEL_W      (SEL_W)
    ) u_lane_sel (
        .req_i  (busReadEnable),
        .idx_o  (lane_sel),
        .valid_o(load_req)
    );

    always_comb begin
        load_val = '0;
        for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
            if (lane_sel == SEL_W'(i)) begin
                load_val = busInputs[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        if (load_req) begin
            op = OP_LOAD;
        end else if (incEnable && !decEnable) begin
            op = OP_INC;
        end else if (decEnable && !incEnable) begin
            op = OP_DEC;
        end else begin
            op = OP_HOLD;
        end
    end

    // MSB of the widened result is the wrap carry / borrow.
    assign inc_sum  = {1'b0, state_q} + (WIDTH+1)'(1);
    assign dec_diff = {1'b0, state_q} - (WIDTH+1)'(1);

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        unique case (op)
            OP_LOAD: begin
                state_d = load_val;
                carry_d = 1'b0;
            end
            OP_INC: begin
                state_d = inc_sum[WIDTH-1:0];
                carry_d = inc_sum[WIDTH];
            end
            OP_DEC: begin
                state_d = dec_diff[WIDTH-1:0];
                carry_d = dec_diff[WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DEFAULT_VALUE;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        busOutputs = '0;
        for (int unsigned j = 0; j < OUTPUT_COUNT; j++) begin
            if (busWriteEnable[j]) begin
                busOutputs[j*WIDTH +: WIDTH] = state_q;
            end
        end
    end

    assign currentValue = state_q;
    assign carryOut     = carry_q;
    assign zeroFlag     = (state_q == '0);

`ifdef BUS_COUNTER_REGISTER_COLLISION_EN
    logic collision_q, collision_d;
    logic multi_load;

    assign multi_load = |(busReadEnable & (busReadEnable - INPUT_COUNT'(1)));

    // A fresh collision outranks a same-cycle clear.
    always_comb begin
        collision_d = collision_q;
        if (multi_load || (load_req && (incEnable || decEnable))) begin
            collision_d = 1'b1;
        end else if (clearError) begin
            collision_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collisionError = collision_q;
`endif

endmodule

// File: tb/tb_bus_counter_register.sv
// Directed self-checking bench for bus_counter_register (8-bit, 3 in, 2 out, reset 8'hFD).
module tb_bus_counter_register;

    logic        clk;
    logic        rst;
    logic [23:0] busInputs;
    logic [2:0]  busReadEnable;
    logic [1:0]  busWriteEnable;
    logic        incEnable;
    logic        decEnable;
    logic [15:0] busOutputs;
    logic [7:0]  currentValue;
    logic        carryOut;
    logic        zeroFlag;
`ifdef BUS_COUNTER_REGISTER_COLLISION_EN
    logic        collisionError;
    logic        clearError;
`endif

    int tests;
    int fails;

    bus_counter_register #(
        .WIDTH        (8),
        .INPUT_COUNT  (3),
        .OUTPUT_COUNT (2),
        .DEFAULT_VALUE(8'hFD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .busInputs     (busInputs),
        .busReadEnable (busReadEnable),
        .busWriteEnable(busWriteEnable),
        .incEnable     (incEnable),
        .decEnable     (decEnable),
        .busOutputs    (busOutputs),
        .currentValue  (currentValue),
        .carryOut      (carryOut),
        .zeroFlag      (zeroFlag)
`ifdef BUS_COUNTER_REGISTER_COLLISION_EN
        ,
        .collisionError(collisionError),
        .clearError    (clearError)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic [7:0] exp_v, input logic exp_c);
        tests++;
        if (currentValue !== exp_v) begin
            fails++;
            $display("FAIL %s value: got %h expected %h", name, currentValue, exp_v);
        end
        tests++;
        if (carryOut !== exp_c) begin
            fails++;
            $display("FAIL %s carry: got %b expected %b", name, carryOut, exp_c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_state("reset", 8'hFD, 1'b0);
        tests++;
        if (busOutputs !== 16'h0000) begin
            fails++;
            $display("FAIL reset busOutputs: got %h expected 0000", busOutputs);
        end
        tests++;
        if (zeroFlag !== 1'b0) begin
            fails++;
            $display("FAIL reset zeroFlag: got %b expected 0", zeroFlag);
        end
    endtask

    task automatic test_load();
        busInputs     = {8'h33, 8'h22, 8'h11};
        busReadEnable = 3'b101;
        step();
        busReadEnable = 3'b000;
        chk_state("load_prio", 8'h33, 1'b0);
        busWriteEnable = 2'b10;
        #1;
        tests++;
        if (busOutputs !== 16'h3300) begin
            fails++;
            $display("FAIL drive_hi: got %h expected 3300", busOutputs);
        end
        busWriteEnable = 2'b01;
        #1;
        tests++;
        if (busOutputs !== 16'h0033) begin
            fails++;
            $display("FAIL drive_lo: got %h expected 0033", busOutputs);
        end
        // Same-cycle load and drive must still show the old value.
        busWriteEnable = 2'b11;
        busReadEnable  = 3'b010;
        #1;
        tests++;
        if (busOutputs !== 16'h3333) begin
            fails++;
            $display("FAIL no_bypass: got %h expected 3333", busOutputs);
        end
        step();
        busReadEnable = 3'b000;
        tests++;
        if (busOutputs !== 16'h2222) begin
            fails++;
            $display("FAIL drive_both: got %h expected 2222", busOutputs);
        end
        busWriteEnable = 2'b00;
    endtask

    task automatic test_inc_wrap();
        busInputs     = {8'h33, 8'h22, 8'hFE};
        busReadEnable = 3'b001;
        step();
        busReadEnable = 3'b000;
        chk_state("load_fe", 8'hFE, 1'b0);
        incEnable = 1'b1;
        step();
        chk_state("inc_ff", 8'hFF, 1'b0);
        step();
        incEnable = 1'b0;
        chk_state("inc_wrap", 8'h00, 1'b1);
        tests++;
        if (zeroFlag !== 1'b1) begin
            fails++;
            $display("FAIL inc_wrap zeroFlag: got %b expected 1", zeroFlag);
        end
        step();
        chk_state("hold_idle", 8'h00, 1'b1);
    endtask

    task automatic test_dec_borrow();
        decEnable = 1'b1;
        step();
        chk_state("dec_borrow", 8'hFF, 1'b1);
        tests++;
        if (zeroFlag !== 1'b0) begin
            fails++;
            $display("FAIL dec_borrow zeroFlag: got %b expected 0", zeroFlag);
        end
        incEnable = 1'b1;
        step();
        chk_state("inc_dec_hold", 8'hFF, 1'b1);
        incEnable = 1'b0;
        step();
        decEnable = 1'b0;
        chk_state("dec_plain", 8'hFE, 1'b0);
    endtask

    task automatic test_load_vs_count();
        // Re-arm carry so the load visibly clears it.
        busInputs     = {8'h33, 8'h22, 8'h00};
        busReadEnable = 3'b001;
        step();
        busReadEnable = 3'b000;
        decEnable     = 1'b1;
        step();
        decEnable = 1'b0;
        chk_state("rearm_carry", 8'hFF, 1'b1);
        busInputs     = {8'h33, 8'h22, 8'h11};
        busReadEnable = 3'b001;
        incEnable     = 1'b1;
        step();
        busReadEnable = 3'b000;
        incEnable     = 1'b0;
        chk_state("load_wins", 8'h11, 1'b0);
`ifdef BUS_COUNTER_REGISTER_COLLISION_EN
        tests++;
        if (collisionError !== 1'b1) begin
            fails++;
            $display("FAIL coll_set: got %b expected 1", collisionError);
        end
        step();
        tests++;
        if (collisionError !== 1'b1) begin
            fails++;
            $display("FAIL coll_sticky: got %b expected 1", collisionError);
        end
        clearError = 1'b1;
        step();
        clearError = 1'b0;
        tests++;
        if (collisionError !== 1'b0) begin
            fails++;
            $display("FAIL coll_clear: got %b expected 0", collisionError);
        end
`endif
        decEnable = 1'b1;
        step();
        decEnable = 1'b0;
        chk_state("dec_after_load", 8'h10, 1'b0);
    endtask

    task automatic test_reset_mid();
        busInputs     = {8'h33, 8'h22, 8'hFF};
        busReadEnable = 3'b001;
        step();
        busReadEnable = 3'b000;
        incEnable     = 1'b1;
        step();
        incEnable = 1'b0;
        chk_state("pre_reset", 8'h00, 1'b1);
`ifdef BUS_COUNTER_REGISTER_COLLISION_EN
        busReadEnable = 3'b110;
        step();
        tests++;
        if (collisionError !== 1'b1) begin
            fails++;
            $display("FAIL coll_multi: got %b expected 1", collisionError);
        end
        incEnable = 1'b1;
        step();
        incEnable = 1'b0;
`endif
        rst           = 1'b1;
        busReadEnable = 3'b010;
        step();
        rst           = 1'b0;
        busReadEnable = 3'b000;
        chk_state("reset_mid", 8'hFD, 1'b0);
`ifdef BUS_COUNTER_REGISTER_COLLISION_EN
        tests++;
        if (collisionError !== 1'b0) begin
            fails++;
            $display("FAIL coll_reset: got %b expected 0", collisionError);
        end
`endif
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst            = 1'b0;
        busInputs      = '0;
        busReadEnable  = '0;
        busWriteEnable = '0;
        incEnable      = 1'b0;
        decEnable      = 1'b0;
`ifdef BUS_COUNTER_REGISTER_COLLISION_EN
        clearError     = 1'b0;
`endif
        #2;
        test_reset();
        test_load();
        test_inc_wrap();
        test_dec_borrow();
        test_load_vs_count();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
